// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg7_pkg;
  typedef enum logic {S_BLANK, S_SHOW} scan_state_t;
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam int DP_BIT = 7;
endpackage

// File: rtl/seg7_scan_ctrl_dec.sv
// Hex nibble to active-high segments, bit order g..a.
module seg7_scan_ctrl_dec (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scanner for a common-bus 7-segment display with
// blanking gaps and frame-boundary double buffering.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int DWELL   = 50000,
  parameter int BLANK   = 500
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp_mask,
  input  logic [NDIGITS-1:0]     en_mask,
  input  logic                   wr,
  output logic [7:0]             leds,
  output logic [NDIGITS-1:0]     ct,
  output logic                   frame_start
);
  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int DW   = $clog2(NDIGITS);

  scan_state_t           state;
  logic [CW-1:0]         cnt;
  logic [DW-1:0]         d;
  logic [4*NDIGITS-1:0]  shown_val, pend_val, use_val;
  logic [NDIGITS-1:0]    shown_dp, shown_en, pend_dp, pend_en, use_dp, use_en;
  logic                  pend_valid;
  logic                  blank_done, show_done, swap, lit;
  logic [3:0]            nib;
  logic [6:0]            seg;
  logic [7:0]            lit_leds;
  logic [NDIGITS-1:0]    onehot;

  assign blank_done = (state == S_BLANK) && (cnt == CW'(BLANK - 1));
  assign show_done  = (state == S_SHOW)  && (cnt == CW'(DWELL - 1));
  assign swap       = blank_done && (d == '0) && pend_valid;

  // Digit 0 of a new frame must already use the freshly swapped buffer.
  assign use_val = swap ? pend_val : shown_val;
  assign use_dp  = swap ? pend_dp  : shown_dp;
  assign use_en  = swap ? pend_en  : shown_en;

  assign nib    = use_val[4*int'(d) +: 4];
  assign lit    = use_en[d];
  assign onehot = NDIGITS'(1) << d;

  seg7_scan_ctrl_dec u_dec (.nib(nib), .seg(seg));

  always_comb begin
    lit_leds         = {1'b0, seg};
    lit_leds[DP_BIT] = use_dp[d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_BLANK;
      cnt         <= '0;
      d           <= '0;
      ct          <= '0;
      leds        <= SEG_OFF;
      frame_start <= 1'b0;
      shown_val   <= '0;
      shown_dp    <= '0;
      shown_en    <= '0;
      pend_val    <= '0;
      pend_dp     <= '0;
      pend_en     <= '0;
      pend_valid  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        S_BLANK: begin
          if (blank_done) begin
            state       <= S_SHOW;
            cnt         <= '0;
            frame_start <= (d == '0);
            ct          <= lit ? onehot : '0;
            leds        <= lit ? lit_leds : SEG_OFF;
            if (swap) begin
              shown_val  <= pend_val;
              shown_dp   <= pend_dp;
              shown_en   <= pend_en;
              pend_valid <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (show_done) begin
            state <= S_BLANK;
            cnt   <= '0;
            d     <= (d == DW'(NDIGITS - 1)) ? '0 : d + 1'b1;
            ct    <= '0;
            leds  <= SEG_OFF;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_BLANK;
      endcase
      // A write on the swap edge lands after the swap, so it wins pend_valid.
      if (wr) begin
        pend_val   <= value;
        pend_dp    <= dp_mask;
        pend_en    <= en_mask;
        pend_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench: a frame-position model predicts pins after each edge.
module tb_seg7_scan_ctrl;
  localparam int ND = 4, DW = 4, BL = 2;
  localparam int SLOT = DW + BL, FR = ND * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0, en_mask = '0;
  logic        wr = 1'b0;
  logic [7:0]  leds;
  logic [3:0]  ct;
  logic        frame_start;

  int checks = 0, failures = 0;
  int k = 0;
  logic [12:0] q[$];

  seg7_scan_ctrl #(.NDIGITS(ND), .DWELL(DW), .BLANK(BL)) dut (
    .clk(clk), .reset(reset), .value(value), .dp_mask(dp_mask),
    .en_mask(en_mask), .wr(wr), .leds(leds), .ct(ct), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  // Model: k counts edges since reset release; frame position r = (k-2) mod FR.
  logic [15:0] m_sv, m_pv;
  logic [3:0]  m_sdp, m_sen, m_pdp, m_pen;
  logic        m_pvld;
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        k = 0; m_sv = '0; m_pv = '0; m_sdp = '0; m_sen = '0;
        m_pdp = '0; m_pen = '0; m_pvld = 1'b0;
        q.delete();
      end else begin
        int r, sl, w;
        logic [12:0] e;
        k++;
        r = (k - 2) % FR;
        if (k >= 2 && r == 0 && m_pvld) begin
          m_sv = m_pv; m_sdp = m_pdp; m_sen = m_pen; m_pvld = 1'b0;
        end
        if (wr) begin
          m_pv = value; m_pdp = dp_mask; m_pen = en_mask; m_pvld = 1'b1;
        end
        e = '0;
        if (k >= 2) begin
          sl = r / SLOT;
          w  = r % SLOT;
          if (w < DW && m_sen[sl]) begin
            e[11:8] = 4'(1 << sl);
            e[7:0]  = {m_sdp[sl], seg_of(m_sv[4*sl +: 4])};
          end
          e[12] = (r == 0);
        end
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (reset) chk("reset_state", {19'b0, frame_start, ct, leds}, 32'd0);
    else if (q.size() > 0) begin
      logic [12:0] e;
      e = q.pop_front();
      chk("pins", {19'b0, frame_start, ct, leds}, {19'b0, e});
    end
  end

  task automatic wait_r(input int target);
    bit hit = 1'b0;
    for (int i = 0; i < 4 * FR; i++) begin
      @(negedge clk);
      if (k >= 2 && ((k - 2) % FR) == target) begin hit = 1'b1; break; end
    end
    if (!hit) chk("wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_wr(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
    value = v; dp_mask = dp; en_mask = en; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    run(3);
    reset = 1'b0;
    run(2 * FR + 5);
    // Mid-frame write: current frame keeps zeros, next frame shows 1234.
    wait_r(7);
    do_wr(16'h1234, 4'b0100, 4'b1111);
    run(2 * FR);
    // Disabled digit 2 stays dark.
    wait_r(3);
    do_wr(16'hFFFF, 4'b0000, 4'b1011);
    run(2 * FR);
    // A pending, B written exactly on the swap edge.
    wait_r(7);
    do_wr(16'hABCD, 4'b0001, 4'b1111);
    wait_r(FR - 1);
    do_wr(16'h5678, 4'b1000, 4'b1111);
    run(2 * FR + 3);
    // Two writes in one frame: only the second is ever seen.
    wait_r(4);
    do_wr(16'hC0C0, 4'b0010, 4'b1111);
    run(3);
    do_wr(16'h0D0D, 4'b0100, 4'b0111);
    run(2 * FR);
    // Async reset during digit 2 SHOW.
    wait_r(2 * SLOT + 1);
    #1 reset = 1'b1;
    #1 chk("async_ct", {28'b0, ct}, 32'd0);
    chk("async_leds", {24'b0, leds}, 32'd0);
    chk("async_fs", {31'b0, frame_start}, 32'd0);
    run(2);
    reset = 1'b0;
    run(FR + 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
